seq_1011_tx: RTL and testbench

//  Serial frame transmitter that pairs with the 1011 Moore sequence detector.
//  - Accepts a parallel word over a valid/ready handshake.
//  - Emits the sync pattern 1011, then the data bits MSB-first, on one serial line.
//  - The detector end uses the sync pattern to locate the start of the frame.
//  - Sits between a parallel producer and the serial link; fully Moore (all outputs registered).

---
 rtl/seq_1011_tx.sv | 183 ++++++++++++++++++
 tb/tb_seq_1011_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_1011_tx.sv
// ---------------------------------------------------------------------------
// seq_1011_tx
// Serial frame transmitter that pairs with the 1011 Moore sequence detector.
// It takes one parallel word over a valid/ready handshake. It then drives the
// sync pattern (MSB-first) followed by the payload (MSB-first) on a single
// registered serial line. Every output is registered (Moore).
//
// Build option:
//   SEQ_TX_PARITY_EN  when defined, an even-parity bit (^payload) is appended
//                     after the data bits. The frame grows to
//                     SYNC_W+DATA_W+1 bits. When undefined, the frame is
//                     SYNC_W+DATA_W bits.
//
// Ports:
//   clk         in   1       clock, rising edge
//   rst         in   1       synchronous reset, active-high, highest priority
//   in_valid    in   1       producer offers in_data
//   in_data     in   DATA_W  payload word, captured at accept
//   in_ready    out  1       word can be accepted (IDLE only)
//   out         out  1       serial line
//   busy        out  1       high on every frame-bit cycle
//   frame_done  out  1       pulse on the cycle carrying the final frame bit
// ---------------------------------------------------------------------------
module seq_1011_tx #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(4'b1011)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   // Only reached when DATA_W >= 2; for DATA_W == 1 the DATA state is always on its last bit.
   localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'(DATA_W - 2);

`ifdef SEQ_TX_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      PAR  = 2'd3
   } state_e;
`else
   localparam bit PARITY_EN = 1'b0;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2
   } state_e;
`endif

   // Elaboration-time sanity on widths
   if (DATA_W < 1) begin : g_bad_data_w
      $error("seq_1011_tx: DATA_W must be >= 1");
   end
   if (SYNC_W < 1) begin : g_bad_sync_w
      $error("seq_1011_tx: SYNC_W must be >= 1");
   end

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [SYNC_W-1:0]   sync_q;
   logic [DATA_W-1:0]   data_q;
   logic                par_q;
   logic                out_q;
   logic                busy_q;
   logic                done_q;
   logic                ready_q;

   // Left-shifted copies; the bit leaving the MSB is the one driven next
   logic [SYNC_W-1:0]   sync_d;
   logic [DATA_W-1:0]   data_d;
   logic [CNT_W-1:0]    cnt_d;

   assign sync_d = sync_q << 1;
   assign data_d = data_q << 1;
   assign cnt_d  = cnt_q + CNT_W'(1);

   // Frame FSM; out/busy/frame_done/in_ready are loaded together with the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sync_q  <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid && ready_q) begin
                  state_q <= SYNC;
                  cnt_q   <= '0;
                  out_q   <= SYNC_PAT[SYNC_W-1];
                  sync_q  <= SYNC_PAT << 1;
                  data_q  <= in_data;
                  par_q   <= ^in_data;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end

            // cnt_q indexes the sync bit currently on the line
            SYNC: begin
               if (cnt_q == SYNC_LAST) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
                  out_q   <= data_q[DATA_W-1];
                  data_q  <= data_d;
                  done_q  <= (DATA_W == 1) && !PARITY_EN;
               end else begin
                  cnt_q   <= cnt_d;
                  out_q   <= sync_q[SYNC_W-1];
                  sync_q  <= sync_d;
               end
            end

            // cnt_q indexes the payload bit currently on the line
            DATA: begin
               if (cnt_q == DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
                  state_q <= PAR;
                  cnt_q   <= '0;
                  out_q   <= par_q;
                  done_q  <= 1'b1;
`else
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  out_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
`endif
               end else begin
                  cnt_q   <= cnt_d;
                  out_q   <= data_q[DATA_W-1];
                  data_q  <= data_d;
                  done_q  <= (cnt_q == DATA_PEN) && !PARITY_EN;
               end
            end

`ifdef SEQ_TX_PARITY_EN
            PAR: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               out_q   <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
`endif

            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               out_q   <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready   = ready_q;
   assign out        = out_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_seq_1011_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_1011_tx
// Directed self-checking bench for seq_1011_tx with the default parameters.
// Expected serial streams are written out by hand. Under SEQ_TX_PARITY_EN,
// each stream carries its parity bit as the final bit.
// ---------------------------------------------------------------------------
module tb_seq_1011_tx;

`ifdef SEQ_TX_PARITY_EN
   localparam int unsigned FL = 13;
   localparam logic [12:0] F_A5 = 13'b1011_1010_0101_0;
   localparam logic [12:0] F_3C = 13'b1011_0011_1100_0;
   localparam logic [12:0] F_FF = 13'b1011_1111_1111_0;
   localparam logic [12:0] F_07 = 13'b1011_0000_0111_1;
`else
   localparam int unsigned FL = 12;
   localparam logic [12:0] F_A5 = 13'b0_1011_1010_0101;
   localparam logic [12:0] F_3C = 13'b0_1011_0011_1100;
   localparam logic [12:0] F_FF = 13'b0_1011_1111_1111;
   localparam logic [12:0] F_07 = 13'b0_1011_0000_0111;
`endif

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out;
   logic       busy;
   logic       frame_done;

   int errors = 0;
   int checks = 0;

   seq_1011_tx dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out        (out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " out"},   32'(out),        32'd0);
      chk({tag, " busy"},  32'(busy),       32'd0);
      chk({tag, " done"},  32'(frame_done), 32'd0);
      chk({tag, " ready"}, 32'(in_ready),   32'd1);
   endtask

   // Called at cycle 1 of a frame; checks cycles 1..n. It then leaves the
   // bench on cycle n+1. chg: cycle where in_data is scrambled to 8'h00.
   // abort: assert rst before the edge that ends cycle n.
   task automatic check_frame(input string tag, input logic [12:0] bits,
                              input int n, input int chg, input bit abort);
      for (int i = 1; i <= n; i++) begin
         chk($sformatf("%s c%0d out", tag, i),   32'(out),        32'(bits[FL-i]));
         chk($sformatf("%s c%0d busy", tag, i),  32'(busy),       32'd1);
         chk($sformatf("%s c%0d done", tag, i),  32'(frame_done), 32'(i == FL));
         chk($sformatf("%s c%0d ready", tag, i), 32'(in_ready),   32'd0);
         if (i == chg) in_data = 8'h00;
         if (abort && i == n) rst = 1'b1;
         tick();
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;

      // 1. reset held two cycles with a pending word
      tick();
      check_idle("rst1");
      tick();
      check_idle("rst2");
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      check_idle("post_rst");

      // 2. single frame
      in_data  = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_frame("a5", F_A5, FL, 0, 1'b0);
      check_idle("a5 gap");

      // 3. held valid, back-to-back frames with one idle cycle
      in_data  = 8'h3C;
      in_valid = 1'b1;
      tick();
      in_data  = 8'hFF;
      check_frame("3c", F_3C, FL, 0, 1'b0);
      check_idle("b2b gap");
      tick();
      in_valid = 1'b0;
      check_frame("ff", F_FF, FL, 0, 1'b0);
      check_idle("ff gap");

      // 4. in_data changed mid-frame has no effect
      in_data  = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_frame("a5chg", F_A5, FL, 6, 1'b0);
      check_idle("a5chg gap");

      // 5. reset at the end of cycle 6 aborts the frame
      in_data  = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_frame("abort", F_A5, 6, 0, 1'b1);
      check_idle("abort c7");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_idle($sformatf("abort idle%0d", i));
      end
      in_data  = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_frame("after_abort", F_A5, FL, 0, 1'b0);
      check_idle("after_abort gap");

      // 6. low-weight payload (parity bit 1 when enabled)
      in_data  = 8'h07;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_frame("07", F_07, FL, 0, 1'b0);
      check_idle("07 gap");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
